// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file slice: default widths, address
// width derivation and the hard-wired zero register index.
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;

  // Address width for a power-of-two register count (never below one bit).
  function automatic int unsigned addr_w(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int unsigned AW_DEF = addr_w(NREG_DEF);

  // Register 0 is hard-wired zero: never written, never busy.
  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Register file bus: packed write ports, packed read ports, issue strobe and
// scoreboard status.
//   wena/waddr/wdata : NWR write ports, port k at [k*W +: W]
//   raddr/rdata      : NRD read ports, rdata combinational
//   rbusy            : per read port, addressed register has pending producer
//   iss_en/iss_rd    : issue strobe marking iss_rd busy
//   busy_cnt         : registered count of busy registers
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2
);
  localparam int unsigned AW = addr_w(NREG);

  logic [NWR-1:0]      wena;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic [AW:0]         busy_cnt;

  modport master (
    output wena, waddr, wdata, raddr, iss_en, iss_rd,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  wena, waddr, wdata, raddr, iss_en, iss_rd,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by issue, cleared by any
// enabled write, with issue winning over a same-cycle write. busy_cnt is the
// registered popcount of the busy bits.
//   clk, rst   : clock, synchronous active-high reset
//   wena/waddr : write ports (clear busy)
//   iss_en/rd  : issue (set busy)
//   busy       : current busy bits
//   busy_cnt   : number of busy registers
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NWR  = 2,
  parameter int unsigned AW   = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wena,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy,
  output logic [AW:0]       busy_cnt
);

  logic [NREG-1:0] busy_d, busy_q;
  logic [AW:0]     cnt_d, cnt_q;

  always_comb begin
    busy_d = busy_q;
    // Clears first, then the issue set, so a new producer survives its
    // same-cycle write.
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wena[k]) busy_d[waddr[k*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (rst) busy_d = '0;

    cnt_d = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
    cnt_q  <= cnt_d;
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with busy-bit scoreboard.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (clears registers and busy bits)
//   bus  : regfile_sb_if slave -- write ports, async read ports with
//          optional same-cycle write bypass, issue strobe, rbusy, busy_cnt
// Register 0 reads zero, ignores writes and is never busy.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned AW = addr_w(NREG);

  logic [XLEN-1:0]     regs_d [NREG];
  logic [XLEN-1:0]     regs_q [NREG];
  logic [NREG-1:0]     busy;
  logic [NRD*XLEN-1:0] rdata_c;
  logic [NRD-1:0]      rbusy_c;

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wena     (bus.wena),
    .waddr    (bus.waddr),
    .iss_en   (bus.iss_en),
    .iss_rd   (bus.iss_rd),
    .busy     (busy),
    .busy_cnt (bus.busy_cnt)
  );

  // Ascending port order: the highest-index enabled port overwrites last.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (bus.wena[k]) regs_d[bus.waddr[k*AW +: AW]] = bus.wdata[k*XLEN +: XLEN];
    end
    regs_d[REG_X0] = '0;
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) regs_d[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Read mux. With bypass, a same-cycle write to a nonzero address supplies
  // the data and hides the busy bit unless a same-cycle issue re-marks it.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    logic            wr_hit;
    logic            iss_hit;
    rdata_c = '0;
    rbusy_c = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      ra      = bus.raddr[j*AW +: AW];
      val     = regs_q[ra];
      wr_hit  = 1'b0;
      iss_hit = bus.iss_en && (bus.iss_rd == ra) && (ra != AW'(REG_X0));
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (bus.wena[k] && (bus.waddr[k*AW +: AW] == ra) && (ra != AW'(REG_X0))) begin
            val    = bus.wdata[k*XLEN +: XLEN];
            wr_hit = 1'b1;
          end
        end
      end
      rdata_c[j*XLEN +: XLEN] = val;
      rbusy_c[j]              = wr_hit ? iss_hit : busy[ra];
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;

endmodule
